// File: rtl/br_arb_pkg.sv
// Shared types and constants for the branch/SLT comparator arbiter.
package br_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_BR  = 1'b0,
    REQ_SLT = 1'b1
  } req_id_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BLTU) || (f3 == F3_BGEU);
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Illegal encodings fall through to not-taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic less, input logic equal);
    logic taken;
    case (f3)
      F3_BEQ:           taken = equal;
      F3_BNE:           taken = !equal;
      F3_BLT, F3_BLTU:  taken = less;
      F3_BGE, F3_BGEU:  taken = !less;
      default:          taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/br_arb_brcomp.sv
// Shared magnitude/equality comparator, signed or unsigned.
module brcomp
  import br_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_unsigned,
  output logic            less,
  output logic            equal
);

  assign equal = (a == b);
  assign less  = is_unsigned ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/br_arb.sv
// Round-robin arbiter sharing one comparator between a branch unit and an SLT unit.
module br_arb
  import br_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_req_valid,
  output logic            br_req_ready,
  input  logic [XLEN-1:0] br_rs1,
  input  logic [XLEN-1:0] br_rs2,
  input  logic [2:0]      br_funct3,
  output logic            br_resp_valid,
  output logic            br_taken,
  output logic            br_illegal,
  input  logic            slt_req_valid,
  output logic            slt_req_ready,
  input  logic [XLEN-1:0] slt_a,
  input  logic [XLEN-1:0] slt_b,
  input  logic            slt_unsigned,
  output logic            slt_resp_valid,
  output logic [XLEN-1:0] slt_result
);

  state_t          state;
  req_id_t         prio;
  req_id_t         owner;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [2:0]      op_f3;
  logic            op_uns;
  logic            less_q;
  logic            equal_q;
  logic            cmp_less;
  logic            cmp_equal;
  logic            grant_br;
  logic            grant_slt;

  // Grant is combinational so a requester sees ready in the same cycle it asks.
  always_comb begin
    grant_br  = 1'b0;
    grant_slt = 1'b0;
    if (!rst && state == IDLE) begin
      if (br_req_valid && (!slt_req_valid || prio == REQ_BR))
        grant_br = 1'b1;
      else if (slt_req_valid)
        grant_slt = 1'b1;
    end
  end

  assign br_req_ready  = grant_br;
  assign slt_req_ready = grant_slt;

  brcomp #(.XLEN(XLEN)) u_brcomp (
    .a           (op_a),
    .b           (op_b),
    .is_unsigned (op_uns),
    .less        (cmp_less),
    .equal       (cmp_equal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prio           <= REQ_BR;
      owner          <= REQ_BR;
      op_a           <= '0;
      op_b           <= '0;
      op_f3          <= 3'b000;
      op_uns         <= 1'b0;
      less_q         <= 1'b0;
      equal_q        <= 1'b0;
      br_resp_valid  <= 1'b0;
      slt_resp_valid <= 1'b0;
      br_taken       <= 1'b0;
      br_illegal     <= 1'b0;
      slt_result     <= '0;
    end else begin
      br_resp_valid  <= 1'b0;
      slt_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_br || grant_slt) begin
            op_a   <= grant_br ? br_rs1 : slt_a;
            op_b   <= grant_br ? br_rs2 : slt_b;
            op_f3  <= grant_br ? br_funct3 : F3_BEQ;
            op_uns <= grant_br ? f3_unsigned(br_funct3) : slt_unsigned;
            owner  <= grant_br ? REQ_BR : REQ_SLT;
            // Point at the loser so the next contested grant goes the other way.
            prio   <= grant_br ? REQ_SLT : REQ_BR;
            state  <= CMP;
          end
        end
        CMP: begin
          less_q  <= cmp_less;
          equal_q <= cmp_equal;
          state   <= RESP;
        end
        RESP: begin
          if (owner == REQ_BR) begin
            br_resp_valid <= 1'b1;
            br_illegal    <= f3_illegal(op_f3);
            br_taken      <= branch_taken(op_f3, less_q, equal_q);
          end else begin
            slt_resp_valid <= 1'b1;
            slt_result     <= {{(XLEN-1){1'b0}}, less_q};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_br_arb.sv
// Self-checking bench for br_arb: directed scenarios plus a cycle-level reference model.
module tb_br_arb;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            br_req_valid;
  logic            br_req_ready;
  logic [XLEN-1:0] br_rs1;
  logic [XLEN-1:0] br_rs2;
  logic [2:0]      br_funct3;
  logic            br_resp_valid;
  logic            br_taken;
  logic            br_illegal;
  logic            slt_req_valid;
  logic            slt_req_ready;
  logic [XLEN-1:0] slt_a;
  logic [XLEN-1:0] slt_b;
  logic            slt_unsigned;
  logic            slt_resp_valid;
  logic [XLEN-1:0] slt_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  br_arb #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .br_req_valid   (br_req_valid),
    .br_req_ready   (br_req_ready),
    .br_rs1         (br_rs1),
    .br_rs2         (br_rs2),
    .br_funct3      (br_funct3),
    .br_resp_valid  (br_resp_valid),
    .br_taken       (br_taken),
    .br_illegal     (br_illegal),
    .slt_req_valid  (slt_req_valid),
    .slt_req_ready  (slt_req_ready),
    .slt_a          (slt_a),
    .slt_b          (slt_b),
    .slt_unsigned   (slt_unsigned),
    .slt_resp_valid (slt_resp_valid),
    .slt_result     (slt_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference compare via a 33-bit subtraction: the borrow/sign bit is the less-than.
  function automatic logic ref_less(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic [32:0] d;
    if (uns) d = {1'b0, a} - {1'b0, b};
    else     d = {a[31], a} - {b[31], b};
    return d[32];
  endfunction

  function automatic void ref_branch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                     output logic taken, output logic illegal);
    illegal = 1'b0;
    case (f3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = ref_less(a, b, 1'b0);
      3'd5:    taken = !ref_less(a, b, 1'b0);
      3'd6:    taken = ref_less(a, b, 1'b1);
      3'd7:    taken = !ref_less(a, b, 1'b1);
      default: begin taken = 1'b0; illegal = 1'b1; end
    endcase
  endfunction

  // Model: one outstanding job answered exactly 3 cycles after its accept cycle.
  initial begin : model
    bit          pend, pend_slt, m_prio, g_br, g_slt, due;
    int          pend_cyc, br_wait, slt_wait;
    logic        pend_tk, pend_il, exp_tk, exp_il;
    logic [31:0] pend_res, exp_res;
    pend = 0; pend_slt = 0; m_prio = 0; pend_cyc = 0; br_wait = 0; slt_wait = 0;
    pend_tk = 0; pend_il = 0; pend_res = 0; exp_tk = 0; exp_il = 0; exp_res = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check_output("rst_br_ready", 32'(br_req_ready), 0);
        check_output("rst_slt_ready", 32'(slt_req_ready), 0);
        pend = 0; m_prio = 0; br_wait = 0; slt_wait = 0;
        exp_tk = 0; exp_il = 0; exp_res = 0;
      end else begin
        due = pend && (pend_cyc == cyc);
        check_output("m_br_resp_valid", 32'(br_resp_valid), 32'(due && !pend_slt));
        check_output("m_slt_resp_valid", 32'(slt_resp_valid), 32'(due && pend_slt));
        if (due) begin
          if (pend_slt) exp_res = pend_res;
          else begin exp_tk = pend_tk; exp_il = pend_il; end
          pend = 0;
        end
        check_output("m_br_taken", 32'(br_taken), 32'(exp_tk));
        check_output("m_br_illegal", 32'(br_illegal), 32'(exp_il));
        check_output("m_slt_result", slt_result, exp_res);
        g_br = 0; g_slt = 0;
        if (!pend) begin
          if (br_req_valid && (!slt_req_valid || !m_prio)) g_br = 1;
          else if (slt_req_valid) g_slt = 1;
        end
        check_output("m_br_ready", 32'(br_req_ready), 32'(g_br));
        check_output("m_slt_ready", 32'(slt_req_ready), 32'(g_slt));
        if (g_br) check_output("m_br_wait_over6", 32'(br_wait > 6), 0);
        if (g_slt) check_output("m_slt_wait_over6", 32'(slt_wait > 6), 0);
        if (!br_req_valid || g_br) br_wait = 0;
        else if (slt_req_valid) br_wait++;
        if (!slt_req_valid || g_slt) slt_wait = 0;
        else if (br_req_valid) slt_wait++;
        if (g_br) begin
          pend = 1; pend_slt = 0; pend_cyc = cyc + 3; m_prio = 1;
          ref_branch(br_rs1, br_rs2, br_funct3, pend_tk, pend_il);
        end else if (g_slt) begin
          pend = 1; pend_slt = 1; pend_cyc = cyc + 3; m_prio = 0;
          pend_res = {31'b0, ref_less(slt_a, slt_b, slt_unsigned)};
        end
      end
    end
  end

  task automatic apply_stimulus_br(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                   output logic tk, output logic il, output int lat);
    int acc_c;
    br_rs1 = a; br_rs2 = b; br_funct3 = f3; br_req_valid = 1'b1;
    acc_c = -1; lat = -1; tk = 1'bx; il = 1'bx;
    for (int i = 0; i < 12 && acc_c < 0; i++) begin
      @(negedge clk);
      if (br_req_ready) acc_c = cyc;
      @(posedge clk); #1;
      if (acc_c >= 0) br_req_valid = 1'b0;
    end
    br_req_valid = 1'b0;
    for (int i = 0; i < 12 && acc_c >= 0 && lat < 0; i++) begin
      @(negedge clk);
      if (br_resp_valid) begin lat = cyc - acc_c; tk = br_taken; il = br_illegal; end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_stimulus_slt(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                    output logic [31:0] res, output int lat);
    int acc_c;
    slt_a = a; slt_b = b; slt_unsigned = uns; slt_req_valid = 1'b1;
    acc_c = -1; lat = -1; res = 'x;
    for (int i = 0; i < 12 && acc_c < 0; i++) begin
      @(negedge clk);
      if (slt_req_ready) acc_c = cyc;
      @(posedge clk); #1;
      if (acc_c >= 0) slt_req_valid = 1'b0;
    end
    slt_req_valid = 1'b0;
    for (int i = 0; i < 12 && acc_c >= 0 && lat < 0; i++) begin
      @(negedge clk);
      if (slt_resp_valid) begin lat = cyc - acc_c; res = slt_result; end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    logic        tk, il, acc_b, acc_s;
    logic [31:0] res;
    int          lat, br_acc, slt_acc, br_resp, slt_resp, seen;
    logic        sim_tk;
    logic [31:0] sim_res;
    bit          acc_ok;

    // Both requesters valid and held across reset exit.
    br_req_valid = 1'b1; br_rs1 = 32'd5; br_rs2 = 32'd5; br_funct3 = 3'b001;
    slt_req_valid = 1'b1; slt_a = 32'd1; slt_b = 32'd2; slt_unsigned = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_output("reset_br_resp_valid", 32'(br_resp_valid), 0);
    check_output("reset_slt_resp_valid", 32'(slt_resp_valid), 0);
    check_output("reset_br_taken", 32'(br_taken), 0);
    check_output("reset_br_illegal", 32'(br_illegal), 0);
    check_output("reset_slt_result", slt_result, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    br_acc = -1; slt_acc = -1; br_resp = -1; slt_resp = -1; sim_tk = 1'bx; sim_res = 'x;
    for (int i = 0; i < 20 && (br_resp < 0 || slt_resp < 0); i++) begin
      @(negedge clk);
      if (br_req_valid && br_req_ready) br_acc = cyc;
      if (slt_req_valid && slt_req_ready) slt_acc = cyc;
      if (br_resp_valid) begin br_resp = cyc; sim_tk = br_taken; end
      if (slt_resp_valid) begin slt_resp = cyc; sim_res = slt_result; end
      @(posedge clk); #1;
      if (br_acc >= 0) br_req_valid = 1'b0;
      if (slt_acc >= 0) slt_req_valid = 1'b0;
    end
    br_req_valid = 1'b0; slt_req_valid = 1'b0;
    check_output("sim_br_granted_first", 32'(br_acc >= 0 && (slt_acc < 0 || br_acc < slt_acc)), 1);
    check_output("sim_slt_grant_gap", slt_acc - br_acc, 3);
    check_output("sim_br_latency", br_resp - br_acc, 3);
    check_output("sim_br_taken", 32'(sim_tk), 0);
    check_output("sim_slt_result", sim_res, 1);
    check_output("sim_resp_gap", slt_resp - br_resp, 3);

    @(posedge clk); #1;
    br_req_valid = 1'b1; br_rs1 = 32'd1; br_rs2 = 32'd1; br_funct3 = 3'b000;
    slt_req_valid = 1'b1; slt_a = 32'd3; slt_b = 32'd3; slt_unsigned = 1'b0;
    @(negedge clk);
    check_output("pair2_br_ready", 32'(br_req_ready), 1);
    check_output("pair2_slt_ready", 32'(slt_req_ready), 0);
    @(posedge clk); #1;
    br_req_valid = 1'b0; slt_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    apply_stimulus_br(32'h0000_1234, 32'h0000_1234, 3'b000, tk, il, lat);
    check_output("beq_latency", lat, 3);
    check_output("beq_taken", 32'(tk), 1);
    apply_stimulus_br(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, tk, il, lat);
    check_output("blt_taken", 32'(tk), 1);
    apply_stimulus_br(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, tk, il, lat);
    check_output("bltu_taken", 32'(tk), 0);
    apply_stimulus_br(32'h0000_0009, 32'h0000_0009, 3'b101, tk, il, lat);
    check_output("bge_equal_taken", 32'(tk), 1);
    apply_stimulus_br(32'h0000_0007, 32'h0000_0009, 3'b010, tk, il, lat);
    check_output("illegal_flag", 32'(il), 1);
    check_output("illegal_taken", 32'(tk), 0);
    apply_stimulus_slt(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, res, lat);
    check_output("sltu_max_vs_one", res, 0);
    apply_stimulus_slt(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, res, lat);
    check_output("slt_neg_vs_one", res, 1);

    // Reset while the SLT sits in CMP; it must vanish without a response.
    slt_a = 32'h8000_0000; slt_b = 32'h7FFF_FFFF; slt_unsigned = 1'b0; slt_req_valid = 1'b1;
    acc_ok = 0;
    for (int i = 0; i < 12 && !acc_ok; i++) begin
      @(negedge clk);
      if (slt_req_ready) acc_ok = 1;
      if (!acc_ok) begin @(posedge clk); #1; end
    end
    check_output("midrst_accept", 32'(acc_ok), 1);
    @(posedge clk); #1;
    slt_req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (slt_resp_valid || br_resp_valid) seen++;
    end
    check_output("midrst_no_resp", seen, 0);
    check_output("midrst_slt_result", slt_result, 0);
    check_output("midrst_br_taken", 32'(br_taken), 0);
    check_output("midrst_br_illegal", 32'(br_illegal), 0);
    @(posedge clk); #1;
    apply_stimulus_slt(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, res, lat);
    check_output("replay_latency", lat, 3);
    check_output("replay_slt_result", res, 1);

    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      acc_b = br_req_valid && br_req_ready;
      acc_s = slt_req_valid && slt_req_ready;
      @(posedge clk); #1;
      if (acc_b || !br_req_valid || $urandom_range(0, 99) < 15) begin
        br_req_valid = ($urandom_range(0, 99) < 55);
        br_rs1 = rand_op();
        br_rs2 = ($urandom_range(0, 3) == 0) ? br_rs1 : rand_op();
        br_funct3 = 3'($urandom_range(0, 7));
      end
      if (acc_s || !slt_req_valid || $urandom_range(0, 99) < 15) begin
        slt_req_valid = ($urandom_range(0, 99) < 55);
        slt_a = rand_op();
        slt_b = ($urandom_range(0, 3) == 0) ? slt_a : rand_op();
        slt_unsigned = 1'($urandom_range(0, 1));
      end
    end
    br_req_valid = 1'b0; slt_req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/br_arb.md
BR_ARB -- requirements
Module: br_arb

Interface
REQ-001 Parameter XLEN, default 32: operand width; the block SHALL be built and verified only at 32.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port br_req_valid, input, 1: the branch requester presents a compare.
REQ-005 Port br_req_ready, output, 1: the branch request is accepted this cycle.
REQ-006 Port br_rs1 and br_rs2, input, XLEN each: branch operands.
REQ-007 Port br_funct3, input, 3: branch type, with BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
REQ-008 Port br_resp_valid, output, 1: branch result is valid for one cycle.
REQ-009 Port br_taken, output, 1: branch decision.
REQ-010 Port br_illegal, output, 1: br_funct3 was 010 or 011; qualified by br_resp_valid.
REQ-011 Port slt_req_valid, input, 1: the set-less-than requester presents a compare.
REQ-012 Port slt_req_ready, output, 1: the SLT request is accepted this cycle.
REQ-013 Port slt_a and slt_b, input, XLEN each: SLT operands.
REQ-014 Port slt_unsigned, input, 1: 1 selects SLTU, 0 selects SLT.
REQ-015 Port slt_resp_valid, output, 1: SLT result is valid for one cycle.
REQ-016 Port slt_result, output, XLEN: zero-extended 0 or 1.

Function
REQ-017 The block SHALL share one comparator between the two requesters using an FSM with states IDLE, CMP and RESP.
REQ-018 In IDLE, if any request is valid, the block SHALL grant exactly one requester: the granted ready is combinationally 1 in that cycle and the other ready is 0.
  - Accept = valid && ready.
  - On accept, the operands and the type (funct3 or slt_unsigned) are latched and the FSM goes to CMP.
REQ-019 Both ready outputs SHALL be 0 in CMP and RESP.
REQ-020 Arbitration SHALL be round-robin using a priority bit prio (0 = branch first).
  - Both valid: grant the requester named by prio.
  - One valid: grant that requester.
  - On every accept, prio is set to point at the requester that was not granted.
REQ-021 In CMP, the comparator SHALL evaluate the latched operands, less and equal SHALL be registered, and the FSM goes to RESP.
  - Unsigned mode applies for BLTU, BGEU and SLTU.
  - Signed mode applies for all other types.
REQ-022 In RESP, exactly one resp_valid (the granted requester's) SHALL be 1 for one cycle, and the FSM returns to IDLE.
  - Latency: accept at edge N gives resp_valid high in the cycle after edge N+2.
  - Sustained throughput is one compare per 3 cycles.
REQ-023 br_taken SHALL be set by type:
  - BEQ: equal.
  - BNE: !equal.
  - BLT and BLTU: less.
  - BGE and BGEU: !less.
  - Illegal funct3 (010, 011): br_taken=0 and br_illegal=1.
REQ-024 slt_result SHALL be {31'b0, less}.
REQ-025 Responses SHALL NOT be back-pressured; requesters are required to sample them.
REQ-026 br_taken, br_illegal and slt_result SHALL hold their last values outside resp_valid; they are meaningful only with their resp_valid.
REQ-027 Requests whose valid is deasserted before an accept SHALL have no effect, and the block does not require valid to be held.
REQ-028 Signed compare SHALL be true two's-complement.
  - 0x80000000 < 0x7FFFFFFF signed.
  - 0xFFFFFFFF > 0x00000001 unsigned.
  - Equal operands give less=0.

Reset
REQ-029 While rst=1, the block SHALL set:
  - FSM to IDLE and prio to 0.
  - Both ready outputs and both resp_valid outputs to 0.
  - br_taken, br_illegal and slt_result to 0.
  - Latched operands to 0.
REQ-030 A reset asserted in CMP or RESP SHALL abort the transaction with no resp_valid issued, and the first post-reset grant SHALL favour branch.

Structure
REQ-031 A shared package SHALL hold:
  - the state enum (IDLE, CMP, RESP);
  - the funct3 branch constants;
  - the requester ID type.
REQ-032 The block SHALL instantiate exactly one sub-module, brcomp, as the shared comparator, driven only from the latched operand registers.

Verification
REQ-033 BEQ scenario: branch-only BEQ, rs1=rs2=0x1234 -> br_resp_valid 3 cycles after the request cycle, br_taken=1.
REQ-034 BLT vs BLTU scenario, each sent as a separate request:
  - BLT with rs1=0xFFFFFFFF, rs2=1 -> taken=1.
  - BLTU with the same operands -> taken=0.
REQ-035 Simultaneous-valid scenario: branch BNE(5,5) and SLTU(1,2) both valid and held from reset exit:
  - Branch is granted first; br_taken=0.
  - SLT is granted next; slt_result=1.
  - Responses are 3 cycles apart.
  - The next simultaneous pair is granted to branch.
REQ-036 Illegal-funct3 scenario: br_funct3=010 -> br_illegal=1, br_taken=0.
REQ-037 Mid-operation reset scenario: rst pulsed during CMP of an SLT(0x80000000, 0x7FFFFFFF) -> no slt_resp_valid, all outputs 0.
  - Replaying the same SLT afterwards gives slt_result=1.
REQ-038 Random scenario: random valid on both requesters for 10k cycles; the bench checks that each accepted request gets exactly one response, in order, matching a reference model, and that neither requester waits more than 6 cycles once the other requester is also waiting.
